alu_seq: RTL

- Parametrised, registered successor to the combinational RV32I ALU (`alu_design`). Adds valid/ready handshaking on input and output.
- Single-cycle ops finish with latency 1 at full throughput.
- Adds an iterative shift-add multiplier covering MUL/MULH/MULHSU/MULHU.
- Sits in the execute stage between operand select and writeback.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_iter.sv | 92 +++++++++
 rtl/alu_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential RV32I-style ALU.
//   - 4-bit operation encodings carried on Data_sel
//   - FSM state type for the top-level sequencer
//   - is_mul(): true for the four iterative multiply operations
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_SLL    = 4'b0010;
  localparam logic [3:0] OP_SLT    = 4'b0011;
  localparam logic [3:0] OP_SLTU   = 4'b0100;
  localparam logic [3:0] OP_XOR    = 4'b0101;
  localparam logic [3:0] OP_SRL    = 4'b0110;
  localparam logic [3:0] OP_SRA    = 4'b0111;
  localparam logic [3:0] OP_OR     = 4'b1000;
  localparam logic [3:0] OP_AND    = 4'b1001;
  localparam logic [3:0] OP_MUL    = 4'b1010;
  localparam logic [3:0] OP_MULH   = 4'b1011;
  localparam logic [3:0] OP_MULHSU = 4'b1100;
  localparam logic [3:0] OP_MULHU  = 4'b1101;
  localparam logic [3:0] OP_PASSB  = 4'b1110;
  localparam logic [3:0] OP_RSVD   = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier (one partial product per cycle).
// Operands are converted to magnitudes on start, multiplied unsigned over
// XLEN steps, and the sign is reapplied on the final step.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        abandon the in-flight multiply
//   start        capture op/a/b and begin (only asserted while idle)
//   op           MUL / MULH / MULHSU / MULHU
//   a, b         operands
//   busy         a multiply is iterating
//   done         combinational pulse during the final step
//   result       valid while done: low half for MUL, high half otherwise
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] acc_q;     // running product
  logic [2*XLEN-1:0] mcand_q;   // |a| shifted left one place per step
  logic [XLEN-1:0]   mplier_q;  // |b| shifted right one place per step
  logic [SHW-1:0]    cnt_q;
  logic              neg_q;
  logic              hi_sel_q;
  logic              busy_q;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] step_sum, prod;
  logic              last;

  // Two's-complement negation of the most negative value wraps back to
  // itself, which read as unsigned is exactly its magnitude.
  assign a_neg = a[XLEN-1] && (op == OP_MUL || op == OP_MULH || op == OP_MULHSU);
  assign b_neg = b[XLEN-1] && (op == OP_MUL || op == OP_MULH);
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod     = neg_q ? -step_sum : step_sum;
  assign last     = busy_q && (cnt_q == SHW'(XLEN - 1));

  assign busy   = busy_q;
  assign done   = last;
  assign result = hi_sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

  // NOTE: the datapath registers are reset along with the control bits so the
  // block leaves reset in a fully defined state; they are not a memory array.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_sel_q <= 1'b0;
      busy_q   <= 1'b0;
    end else if (flush) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, a_mag};
      mplier_q <= b_mag;
      neg_q    <= a_neg ^ b_neg;
      hi_sel_q <= (op != OP_MUL);
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= step_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SHW'(1);   // wraps to 0 on the final step
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops produce a result on the accepting edge's successor at full
// throughput; multiplies run through alu_mul_iter and return XLEN+1 cycles
// after acceptance.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 kill in-flight multiply and any held result
//   in_valid / in_ready   operand handshake (A, B, Data_sel)
//   out_valid / out_ready result handshake (res)
//   busy                  multiply in progress
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      Data_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            in_fire, out_fire;
  logic            mul_start, mul_done;
  logic [XLEN-1:0] mul_res;

  // A held result blocks new work unless it is being drained this cycle.
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign mul_start = in_fire && is_mul(Data_sel);
  assign shamt     = B[SHW-1:0];

  assign out_valid = out_valid_q;
  assign res       = res_q;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    alu_res = '0;
    unique case (Data_sel)
      OP_ADD:   alu_res = A + B;
      OP_SUB:   alu_res = A - B;
      OP_SLL:   alu_res = A << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (A < B)};
      OP_XOR:   alu_res = A ^ B;
      OP_SRL:   alu_res = A >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(A) >>> shamt);
      OP_OR:    alu_res = A | B;
      OP_AND:   alu_res = A & B;
      OP_PASSB: alu_res = B;
      default:  alu_res = '0;   // multiplies take their own path; 1111 reserved
    endcase
  end

  alu_mul_iter #(.XLEN(XLEN), .SHW(SHW)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (mul_start),
    .op     (Data_sel),
    .a      (A),
    .b      (B),
    .busy   (busy),
    .done   (mul_done),
    .result (mul_res)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_fire;
    res_d       = res_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_fire) begin
            if (is_mul(Data_sel)) begin
              state_d = ST_MUL;
            end else begin
              out_valid_d = 1'b1;
              res_d       = alu_res;
            end
          end
        end
        ST_MUL: begin
          // The output slot was free or draining at accept, so completion
          // never has to wait.
          if (mul_done) begin
            out_valid_d = 1'b1;
            res_d       = mul_res;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

endmodule
